// File: rtl/rr_arb_out_buffer.sv
// rr_arb_out_buffer
//   Output stage for the round-robin FIFO arbiter. The arbiter streams bytes as
//   dout/valid and cannot be stalled. This block captures that stream into a small
//   first-word-fall-through buffer and re-issues it to the consumer on a valid/ready
//   handshake. Words that arrive while the buffer is full and not being popped are
//   dropped, and the drop is flagged.
//
//   Optional feature: define RR_OUT_DROP_CNT_EN to build the saturating drop counter.
//   When the macro is undefined, drop_cnt is tied to zero and the port list is unchanged.
//
// Ports
//   clk        in   clock, all state on the rising edge
//   rst        in   asynchronous active-high reset
//   in_data    in   arbiter data word
//   in_valid   in   arbiter valid qualifier
//   out_data   out  head-of-buffer word, combinational from storage
//   out_valid  out  head word present (buffer not empty)
//   out_ready  in   consumer accepts the head when out_valid && out_ready
//   count      out  words held, 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
//   overflow   out  sticky flag, at least one word dropped
//   clr_ovf    in   synchronous clear of overflow (and of drop_cnt)
//   drop_cnt   out  number of dropped words, saturating at 8'hFF

module rr_arb_out_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic [7:0]        drop_cnt
);

    localparam logic [ADDR_W:0] FullCount = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push;
    logic              pop;
    logic              drop;

    assign full      = (count == FullCount);
    assign empty     = (count == '0);
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr];

    // A full buffer still accepts a word when the head leaves in the same cycle.
    assign pop  = out_valid && out_ready;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    // Storage is intentionally not reset; out_data is only meaningful with out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // A drop in the same cycle as clr_ovf keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

`ifdef RR_OUT_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= 8'h00;
        end else if (drop) begin
            if (clr_ovf) begin
                drop_cnt_q <= 8'h01;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end else if (clr_ovf) begin
            drop_cnt_q <= 8'h00;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_rr_arb_out_buffer.sv
// tb_rr_arb_out_buffer
//   Directed bench for rr_arb_out_buffer (DEPTH=8). Inputs change 1 time unit after
//   each rising edge and outputs are sampled there too, away from the active edge.

module tb_rr_arb_out_buffer;

`ifdef RR_OUT_DROP_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clr_ovf;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    rr_arb_out_buffer #(
        .DATA_W(8),
        .DEPTH (8),
        .ADDR_W(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] q[$];
    logic [7:0] ord_vals[4];
    int         n_recv;
    bit         pop_m;

    initial begin
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        ord_vals[0] = 8'd87;
        ord_vals[1] = 8'd56;
        ord_vals[2] = 8'd9;
        ord_vals[3] = 8'd12;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rst = 1'b0;
        tick();

        // Order: each word appears one cycle after its push
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = ord_vals[i];
            chk("ord_pre_count", count, (i == 0) ? 0 : 1);
            tick();
            chk("ord_valid", out_valid, 1);
            chk("ord_data", out_data, ord_vals[i]);
            chk("ord_count", count, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("ord_empty", empty, 1);
        chk("ord_count_end", count, 0);

        // Fill and overflow
        out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
            if (i == 8) begin
                chk("fill_full8", full, 1);
                chk("fill_count8", count, 8);
                chk("fill_ovf8", overflow, 0);
            end
        end
        in_valid = 1'b0;
        chk("ovf_count", count, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop_cnt", drop_cnt, CntEn ? 2 : 0);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("ovf_drain", out_data, i);
            tick();
        end
        out_ready = 1'b0;
        chk("ovf_drained", empty, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_cleared", overflow, 0);
        chk("ovf_cnt_cleared", drop_cnt, 0);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        in_data   = 8'd85;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("pp_count", count, 8);
        chk("pp_full", full, 1);
        chk("pp_ovf", overflow, 0);
        chk("pp_head", out_data, 2);
        out_ready = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            chk("pp_drain", out_data, (i == 9) ? 85 : i);
            tick();
        end
        out_ready = 1'b0;
        chk("pp_empty", empty, 1);

        // Wrap: 20 pushes interleaved with pops, checked against a queue model
        n_recv = 0;
        for (int k = 0; k < 46; k++) begin
            in_valid  = (k < 40) && (k % 2 == 0);
            in_data   = 8'(100 + k / 2);
            out_ready = (k % 3 != 0);
            chk("wrap_valid", out_valid, (q.size() != 0));
            pop_m = (q.size() != 0) && out_ready;
            if (pop_m) begin
                chk("wrap_data", out_data, q[0]);
                chk("wrap_seq", out_data, 100 + n_recv);
                void'(q.pop_front());
                n_recv++;
            end
            if (in_valid) q.push_back(in_data);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("wrap_recv", n_recv, 20);
        chk("wrap_empty", count, 0);
        chk("wrap_no_ovf", overflow, 0);

        // Clear race: drop and clr_ovf in the same cycle
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h20 + i);
            tick();
        end
        in_data = 8'hEE;
        tick();
        chk("race_ovf_set", overflow, 1);
        chk("race_cnt1", drop_cnt, CntEn ? 1 : 0);
        clr_ovf = 1'b1;
        tick();
        chk("race_ovf_hold", overflow, 1);
        chk("race_cnt_restart", drop_cnt, CntEn ? 1 : 0);
        in_valid = 1'b0;
        tick();
        clr_ovf = 1'b0;
        chk("race_ovf_clr", overflow, 0);
        chk("race_cnt_clr", drop_cnt, 0);
        chk("race_count", count, 8);
        chk("race_head", out_data, 8'h20);

        // Set overflow again, then leave 3 words held and reset mid-cycle
        in_valid = 1'b1;
        in_data  = 8'hEF;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        out_ready = 1'b0;
        chk("mrst_pre_count", count, 3);
        chk("mrst_pre_ovf", overflow, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("mrst_count", count, 0);
        chk("mrst_empty", empty, 1);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_ovf", overflow, 0);
        chk("mrst_drop_cnt", drop_cnt, 0);
        #2;
        rst = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data  = 8'h57;
        tick();
        in_valid = 1'b0;
        chk("mrst_head", out_data, 8'h57);
        chk("mrst_head_valid", out_valid, 1);
        chk("mrst_head_count", count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
